// File: rtl/rectify.sv
// Clamped piecewise-linear activation with a derivative-mask FIFO that gates
// backward errors on their way back to the upstream accumulator.
module rectify #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SAT   = 16'h00ff,
  parameter int unsigned      DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             arg_valid,
  output logic             arg_ready,
  input  logic [WIDTH-1:0] arg_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  input  logic             err_valid,
  output logic             err_ready,
  input  logic [WIDTH-1:0] err_data,
  output logic             fbk_valid,
  input  logic             fbk_ready,
  output logic [WIDTH-1:0] fbk_data
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [DEPTH-1:0] masks;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;

  logic             lo;
  logic             hi;
  logic [WIDTH-1:0] act;
  logic             msk;
  logic             arg_fire;
  logic             err_fire;
  logic             push;

  // SAT is positive, so once the sign bit is clear an unsigned compare suffices
  always_comb begin
    lo  = arg_data[WIDTH-1] || (arg_data == '0);
    hi  = !arg_data[WIDTH-1] && (arg_data >= SAT);
    act = arg_data;
    msk = 1'b1;
    if (lo) begin
      act = '0;
      msk = 1'b0;
    end else if (hi) begin
      act = SAT;
      msk = 1'b0;
    end
  end

  // Readiness uses the registered count only; a same-cycle pop frees nothing
  assign arg_ready = (!res_valid || res_ready) && (!en || (count < FULL));
  assign err_ready = (!fbk_valid || fbk_ready) && (count != '0);
  assign arg_fire  = arg_valid && arg_ready;
  assign err_fire  = err_valid && err_ready;
  assign push      = arg_fire && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      fbk_valid <= 1'b0;
      fbk_data  <= '0;
      masks     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
    end else begin
      if (arg_fire) begin
        res_valid <= 1'b1;
        res_data  <= act;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      if (err_fire) begin
        fbk_valid <= 1'b1;
        fbk_data  <= masks[rptr] ? err_data : '0;
        rptr      <= rptr + 1'b1;
      end else if (fbk_ready) begin
        fbk_valid <= 1'b0;
      end

      if (push) begin
        masks[wptr] <= msk;
        wptr        <= wptr + 1'b1;
      end

      case ({push, err_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rectify.sv
// Scoreboard bench for rectify: stimulus predicts handshakes from a queue-based
// model and pushes expected results; a monitor compares whatever the DUT presents.
module tb_rectify;

  localparam int D   = 4;
  localparam int SAT = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        arg_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        err_valid = 1'b0;
  logic        fbk_ready = 1'b0;
  logic [15:0] arg_data = '0;
  logic [15:0] err_data = '0;
  logic        arg_ready, res_valid, err_ready, fbk_valid;
  logic [15:0] res_data, fbk_data;

  rectify #(.WIDTH(16), .SAT(16'h00ff), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] res_q[$];
  logic [15:0] fbk_q[$];
  bit          mq[$];
  bit          res_take = 0;
  bit          fbk_take = 0;
  bit          was_rst = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_act(logic [15:0] a);
    int v = int'($signed(a));
    if (v <= 0) return 16'h0000;
    if (v >= SAT) return 16'(SAT);
    return a;
  endfunction

  function automatic bit ref_mask(logic [15:0] a);
    int v = int'($signed(a));
    return (v > 0) && (v < SAT);
  endfunction

  // Monitor: retire what was consumed at the last edge, then compare the front
  initial forever begin
    @(negedge clk);
    #1;
    if (res_take && res_q.size() > 0) void'(res_q.pop_front());
    if (fbk_take && fbk_q.size() > 0) void'(fbk_q.pop_front());
    chk("res_valid", res_valid, res_q.size() != 0);
    chk("fbk_valid", fbk_valid, fbk_q.size() != 0);
    if (res_q.size() != 0) chk("res_data", res_data, res_q[0]);
    if (fbk_q.size() != 0) chk("fbk_data", fbk_data, fbk_q[0]);
  end

  task automatic cycle(bit r, bit e, bit av, logic [15:0] ad, bit rr,
                       bit ev, logic [15:0] ed, bit fr);
    bit exp_ar, exp_er, m;
    @(negedge clk);
    #2;
    rst = r; en = e; arg_valid = av; arg_data = ad; res_ready = rr;
    err_valid = ev; err_data = ed; fbk_ready = fr;
    #1;
    if (r) begin
      res_q.delete(); fbk_q.delete(); mq.delete();
      res_take = 0; fbk_take = 0; was_rst = 1;
    end else begin
      if (was_rst) begin
        chk("res_data_rst", res_data, 16'h0000);
        chk("fbk_data_rst", fbk_data, 16'h0000);
        was_rst = 0;
      end
      exp_ar = (res_q.size() == 0 || rr) && (!e || mq.size() < D);
      exp_er = (fbk_q.size() == 0 || fr) && (mq.size() > 0);
      chk("arg_ready", arg_ready, exp_ar);
      chk("err_ready", err_ready, exp_er);
      res_take = (res_q.size() != 0) && rr;
      fbk_take = (fbk_q.size() != 0) && fr;
      if (ev && exp_er) begin
        m = mq.pop_front();
        fbk_q.push_back(m ? ed : 16'h0000);
      end
      if (av && exp_ar) begin
        res_q.push_back(ref_act(ad));
        if (e) mq.push_back(ref_mask(ad));
      end
    end
  endtask

  logic [15:0] clamp_vals [5] = '{16'h8000, 16'h0000, 16'h0040, 16'h00ff, 16'h7fff};
  logic [15:0] edge_vals [8]  = '{16'h0000, 16'h0001, 16'h00fe, 16'h00ff,
                                  16'h0100, 16'hffff, 16'h8000, 16'h7fff};

  function automatic logic [15:0] pick_arg();
    if ($urandom_range(3) == 0) return edge_vals[$urandom_range(7)];
    return 16'($urandom);
  endfunction

  initial begin
    cycle(1, 0, 0, '0, 0, 0, '0, 0);

    // Clamp with learning off: nothing queued, err never accepted
    foreach (clamp_vals[i]) cycle(0, 0, 1, clamp_vals[i], 1, 1, 16'h1234, 1);
    cycle(0, 0, 0, '0, 1, 1, 16'h1234, 1);

    // Gating
    cycle(0, 1, 1, 16'h0040, 1, 0, '0, 1);
    cycle(0, 1, 1, 16'hfff0, 1, 0, '0, 1);
    cycle(0, 1, 0, '0, 1, 1, 16'h0010, 1);
    cycle(0, 1, 0, '0, 1, 1, 16'hfff8, 1);
    cycle(0, 1, 0, '0, 1, 0, '0, 1);

    // Full FIFO, then a pop with a forward that must not slip in
    for (int i = 0; i < D; i++) cycle(0, 1, 1, 16'h0010 + 16'(i), 1, 0, '0, 1);
    cycle(0, 1, 1, 16'h0077, 1, 0, '0, 1);
    cycle(0, 1, 1, 16'h0055, 1, 1, 16'h0abc, 1);
    cycle(0, 1, 1, 16'h0066, 1, 0, '0, 1);
    for (int i = 0; i < D + 2; i++) cycle(0, 0, 0, '0, 1, 1, 16'(i), 1);

    // Empty FIFO stall, then a learning forward unblocks it
    cycle(0, 1, 0, '0, 1, 1, 16'h0321, 1);
    cycle(0, 1, 1, 16'h0020, 1, 1, 16'h0321, 1);
    cycle(0, 1, 0, '0, 1, 1, 16'h0321, 1);
    cycle(0, 1, 0, '0, 1, 0, '0, 1);

    // Backpressure on both outputs
    cycle(0, 1, 1, 16'h0030, 1, 0, '0, 1);
    cycle(0, 1, 1, 16'h0031, 1, 1, 16'h0444, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 16'h0032, 0, 1, 16'h0555, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, 1, 1, 16'h0666, 1);

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 150; i++) begin
        bit e  = (ph % 4 == 3) ? ($urandom_range(3) == 0) : ($urandom_range(7) != 0);
        bit av = $urandom_range(3) != 0;
        bit ev = (ph % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
        cycle(0, e, av, pick_arg(), $urandom_range(3) != 0,
              ev, 16'($urandom), $urandom_range(3) != 0);
      end
    end

    // Reset with queued masks and a pending result
    for (int i = 0; i < D + 4; i++) cycle(0, 0, 0, '0, 1, 1, 16'h0111, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 16'h0050, 1, 0, '0, 0);
    cycle(1, 1, 0, '0, 0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0, 1, 16'h0222, 0);
    cycle(0, 1, 1, 16'h0060, 1, 1, 16'h0222, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1, 0, '0, 1);

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
